seq_multiplier: RTL and testbench

Parametrised, iterative shift-and-add multiplier that computes the 2·WIDTH-bit product of two WIDTH-bit operands over WIDTH/DIGIT cycles. It supports both unsigned and two's-complement signed operands. It replaces the fixed 4-bit combinational array multiplier in the matrix-multiply datapath wherever area matters more than latency. It sits between the operand fetch logic and the accumulator, with valid/ready handshakes on both sides.

---
 rtl/mult_pkg.sv | 32 +++
 rtl/mult_digit.sv | 24 ++
 rtl/seq_multiplier.sv | 151 +++++++++++++++
 tb/tb_seq_multiplier.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative shift-and-add multiplier.
package mult_pkg;

  // Controller states: accept operands, iterate over digits, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Default geometry matches the 4-bit array multiplier this block replaces.
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DIGIT = 1;

  // Number of BUSY iterations: one per DIGIT-bit slice of the multiplier.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Iteration counter width, wide enough to hold N itself.
  function automatic int calc_cw(input int width, input int digit);
    return $clog2(calc_n(width, digit) + 1);
  endfunction

  // Legal geometries: WIDTH >= 2, DIGIT in {1,2,4}, WIDTH a whole number of digits.
  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) &&
           ((digit == 1) || (digit == 2) || (digit == 4)) &&
           ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational partial product: WIDTH-bit multiplicand times one DIGIT-bit digit.
// Kept separate so a radix-4 Booth recoder can later replace the digit source.
module mult_digit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [WIDTH-1:0]       i_mcand,
  input  logic [DIGIT-1:0]       i_digit,
  output logic [WIDTH+DIGIT-1:0] o_pp
);

  // Sum the multiplicand shifted by each set digit bit; the result fits WIDTH+DIGIT bits.
  always_comb begin
    o_pp = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i_digit[i]) begin
        o_pp = o_pp + ({{DIGIT{1'b0}}, i_mcand} << i);
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, unsigned or two's complement, retiring DIGIT
// multiplier bits per cycle. Operands are converted to magnitudes on entry and the
// sign is reapplied once, on the final accumulation step.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 exactly in IDLE and out_valid is 1 exactly in DONE; both are decoded
// from the state register only, so neither depends combinationally on in_valid or
// out_ready. product is held unchanged for as long as out_valid is high.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output mult_state_t        o_dbg_state
);

  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = calc_cw(WIDTH, DIGIT);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("seq_multiplier: WIDTH must be >= 2 and a multiple of DIGIT, DIGIT in {1,2,4}");
  end

  mult_state_t            r_state;
  mult_state_t            w_next_state;
  logic                   w_accept;
  logic                   w_step;
  logic                   w_last;

  logic [WIDTH-1:0]       r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic                   r_neg;
  logic [PW-1:0]          r_acc;
  logic [PW-1:0]          r_product;
  logic [CW-1:0]          r_count;

  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic                   w_neg;
  logic [WIDTH+DIGIT-1:0] w_pp;
  logic [PW-1:0]          w_pp_wide;
  logic [31:0]            w_shamt;
  logic [PW-1:0]          w_addend;
  logic [PW-1:0]          w_acc_next;

  // Magnitudes in WIDTH bits: the most negative value negates to itself, which read
  // as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  assign w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign w_neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  mult_digit #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) u_digit (
    .i_mcand(r_mcand),
    .i_digit(r_mplier[DIGIT-1:0]),
    .o_pp   (w_pp)
  );

  // Align this cycle's partial product to its digit position and accumulate.
  assign w_pp_wide  = PW'(w_pp);
  assign w_shamt    = 32'(r_count) * 32'(DIGIT);
  assign w_addend   = w_pp_wide << w_shamt;
  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_count == LAST_COUNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand capture, digit iteration and sign-corrected result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_neg    <= w_neg;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> DIGIT;
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_product <= r_neg ? -w_acc_next : w_acc_next;
      end
    end
  end

  assign product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: four instances (W4/D1, W4/D2, W4/D4, W8/D2) sharing clock
// and reset. Directed vectors, backpressure and mid-operation reset sequences, then
// throttled streams checked through an expected-result queue.
module tb_seq_multiplier;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [3:0]  sm;
  logic [7:0]  ta [4];
  logic [7:0]  tbv[4];
  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic [7:0]  p0, p1, p2;
  logic [15:0] p3;
  mult_state_t s0, s1, s2, s3;

  logic [15:0] exp_q[$];
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  seq_multiplier #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
    .a(ta[0][3:0]), .b(tbv[0][3:0]), .signed_mode(sm[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .product(p0), .o_dbg_state(s0));

  seq_multiplier #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .a(ta[1][3:0]), .b(tbv[1][3:0]), .signed_mode(sm[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .product(p1), .o_dbg_state(s1));

  seq_multiplier #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
    .a(ta[2][3:0]), .b(tbv[2][3:0]), .signed_mode(sm[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .product(p2), .o_dbg_state(s2));

  seq_multiplier #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir3),
    .a(ta[3]), .b(tbv[3]), .signed_mode(sm[3]),
    .out_valid(ov3), .out_ready(ordy[3]), .product(p3), .o_dbg_state(s3));

  // ---------------- instance accessors ----------------
  function automatic int wid(input int d);
    return (d == 3) ? 8 : 4;
  endfunction

  function automatic int iters(input int d);
    case (d)
      0:       return 4;
      1:       return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0:       return ir0;
      1:       return ir1;
      2:       return ir2;
      default: return ir3;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      2:       return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic [15:0] get_prod(input int d);
    case (d)
      0:       return {8'h00, p0};
      1:       return {8'h00, p1};
      2:       return {8'h00, p2};
      default: return p3;
    endcase
  endfunction

  function automatic mult_state_t get_st(input int d);
    case (d)
      0:       return s0;
      1:       return s1;
      2:       return s2;
      default: return s3;
    endcase
  endfunction

  // Reference: plain integer multiply of the interpreted operands, kept to 2*w bits.
  function automatic logic [15:0] ref_mult(input logic [7:0] av, input logic [7:0] bv,
                                           input logic m, input int w);
    longint x, y, p, mask;
    mask = (longint'(1) << w) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (m && x[w-1]) x = x - (longint'(1) << w);
    if (m && y[w-1]) y = y - (longint'(1) << w);
    p = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return p[15:0];
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total_cnt++;
    fail_cnt++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Called at a negedge; returns at a negedge with the instance ready (or after timeout).
  task automatic wait_ready(input int d, input string nm);
    int n;
    n = 0;
    while (!get_ir(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!get_ir(d)) timeout_fail({nm, "_ready"});
  endtask

  // ---------------- driver tasks ----------------
  // One operation with out_ready high: checks latency, in_ready low while busy,
  // product, and return to IDLE after the output handshake.
  task automatic run_directed(input string nm, input int d, input logic [7:0] av,
                              input logic [7:0] bv, input logic m, input logic [15:0] req);
    int  lat;
    bit  seen;
    bit  ir_low;
    wait_ready(d, nm);
    iv[d]   = 1'b1;
    ta[d]   = av;
    tbv[d]  = bv;
    sm[d]   = m;
    ordy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[d]  = 1'b0;
    ta[d]  = 8'($urandom_range(0, 255));
    tbv[d] = 8'($urandom_range(0, 255));
    sm[d]  = 1'($urandom_range(0, 1));
    lat    = 1;
    seen   = 1'b0;
    ir_low = 1'b1;
    while (lat <= 20) begin
      if (get_ov(d)) begin
        seen = 1'b1;
        break;
      end
      if (get_ir(d)) ir_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      timeout_fail({nm, "_out_valid"});
    end else begin
      check({nm, "_latency"}, 32'(lat), 32'(iters(d) + 1));
      check({nm, "_busy_in_ready"}, 32'(ir_low), 32'd1);
      check({nm, "_product"}, 32'(get_prod(d)), 32'(req));
      @(negedge clk);
      check({nm, "_after_out_valid"}, 32'(get_ov(d)), 32'd0);
      check({nm, "_after_in_ready"}, 32'(get_ir(d)), 32'd1);
    end
    ordy[d] = 1'b0;
  endtask

  // Throttled stream: random out_ready, random issue gaps, junk in_valid while busy.
  task automatic run_stream(input int d, input logic m, input int npairs, input bit exhaustive);
    int issued;
    int popped;
    int budget;
    int quiet_ov;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] e;
    issued = 0;
    popped = 0;
    budget = npairs * 40 + 100;
    exp_q.delete();
    while ((issued < npairs || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      // consumer side: handshake happens at the coming edge if out_valid && out_ready
      ordy[d] = ($urandom_range(0, 3) != 0);
      if (get_ov(d) && ordy[d]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("stream_d%0d_m%0d_unexpected", d, m), 32'(get_prod(d)), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          popped++;
          check($sformatf("stream_d%0d_m%0d_pair%0d", d, m, popped - 1), 32'(get_prod(d)), 32'(e));
        end
      end
      // producer side
      if (get_ir(d) && issued < npairs && $urandom_range(0, 2) != 0) begin
        if (exhaustive) begin
          av = 8'(issued & 15);
          bv = 8'(issued >> 4);
        end else begin
          av = 8'($urandom_range(0, 255));
          bv = 8'($urandom_range(0, 255));
        end
        iv[d]  = 1'b1;
        ta[d]  = av;
        tbv[d] = bv;
        sm[d]  = m;
        exp_q.push_back(ref_mult(av, bv, m, wid(d)));
        issued++;
      end else begin
        iv[d]  = get_ir(d) ? 1'b0 : 1'($urandom_range(0, 1));
        ta[d]  = 8'($urandom_range(0, 255));
        tbv[d] = 8'($urandom_range(0, 255));
        sm[d]  = 1'($urandom_range(0, 1));
      end
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    if (budget == 0) timeout_fail($sformatf("stream_d%0d_m%0d", d, m));
    check($sformatf("stream_d%0d_m%0d_count", d, m), 32'(popped), 32'(npairs));
    @(negedge clk);
    quiet_ov = 0;
    repeat (10) begin
      @(negedge clk);
      if (get_ov(d)) quiet_ov++;
    end
    check($sformatf("stream_d%0d_m%0d_no_extra", d, m), 32'(quiet_ov), 32'd0);
    ordy[d] = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] req;
  } vec_t;

  vec_t vecs[12];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int ghost;

    vecs[0]  = '{0, 8'd13,  8'd11,  1'b0, 16'h008F};
    vecs[1]  = '{0, 8'h08,  8'h08,  1'b1, 16'h0040};
    vecs[2]  = '{0, 8'h0D,  8'h05,  1'b1, 16'h00F1};
    vecs[3]  = '{0, 8'h07,  8'h00,  1'b1, 16'h0000};
    vecs[4]  = '{0, 8'h08,  8'h01,  1'b0, 16'h0008};
    vecs[5]  = '{1, 8'h0F,  8'h0F,  1'b0, 16'h00E1};
    vecs[6]  = '{1, 8'h08,  8'h07,  1'b1, 16'h00C8};
    vecs[7]  = '{2, 8'h09,  8'h07,  1'b1, 16'h00CF};
    vecs[8]  = '{2, 8'h0F,  8'h0F,  1'b1, 16'h0001};
    vecs[9]  = '{3, 8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[10] = '{3, 8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[11] = '{3, 8'h80,  8'h7F,  1'b1, 16'hC080};

    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    sm   = '0;
    for (int i = 0; i < 4; i++) begin
      ta[i]  = '0;
      tbv[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state of every instance
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_d%0d_in_ready", d), 32'(get_ir(d)), 32'd1);
      check($sformatf("reset_d%0d_out_valid", d), 32'(get_ov(d)), 32'd0);
      check($sformatf("reset_d%0d_product", d), 32'(get_prod(d)), 32'd0);
      check($sformatf("reset_d%0d_state", d), 32'(get_st(d)), 32'(IDLE));
    end
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    for (int i = 0; i < 12; i++) begin
      run_directed($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].req);
    end

    // backpressure: 9*9 held in DONE for several cycles while in_valid pulses
    wait_ready(0, "bp");
    iv[0]   = 1'b1;
    ta[0]   = 8'd9;
    tbv[0]  = 8'd9;
    sm[0]   = 1'b0;
    ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!get_ov(0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!get_ov(0)) timeout_fail("bp_out_valid");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hold%0d_out_valid", i), 32'(get_ov(0)), 32'd1);
      check($sformatf("bp_hold%0d_product", i), 32'(get_prod(0)), 32'h51);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(get_ir(0)), 32'd0);
      check($sformatf("bp_hold%0d_state", i), 32'(get_st(0)), 32'(DONE));
      if (i < 3) begin
        iv[0]  = 1'b1;
        ta[0]  = 8'($urandom_range(0, 15));
        tbv[0] = 8'($urandom_range(0, 15));
        @(negedge clk);
      end
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 32'(get_ov(0)), 32'd0);
    check("bp_release_in_ready", 32'(get_ir(0)), 32'd1);
    check("bp_release_state", 32'(get_st(0)), 32'(IDLE));
    @(negedge clk);
    check("bp_no_ghost_accept", 32'(get_st(0)), 32'(IDLE));
    ordy[0] = 1'b0;

    // reset during the second BUSY cycle discards the operation
    wait_ready(0, "rst_mid");
    iv[0]   = 1'b1;
    ta[0]   = 8'd15;
    tbv[0]  = 8'd15;
    sm[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_state_busy", 32'(get_st(0)), 32'(BUSY));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(get_ir(0)), 32'd1);
    check("rst_mid_out_valid", 32'(get_ov(0)), 32'd0);
    check("rst_mid_product", 32'(get_prod(0)), 32'd0);
    check("rst_mid_state", 32'(get_st(0)), 32'(IDLE));
    ghost = 0;
    repeat (8) begin
      @(negedge clk);
      if (get_ov(0)) ghost++;
    end
    check("rst_mid_discarded", 32'(ghost), 32'd0);
    run_directed("rst_then_6x7", 0, 8'd6, 8'd7, 1'b0, 16'd42);

    // exhaustive 4-bit streams for every digit size and both modes
    for (int d = 0; d < 3; d++) begin
      run_stream(d, 1'b0, 256, 1'b1);
      run_stream(d, 1'b1, 256, 1'b1);
    end
    // random 8-bit streams
    run_stream(3, 1'b0, 64, 1'b0);
    run_stream(3, 1'b1, 64, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop if something wedges outside the bounded waits.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d passed)", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
